vin_signal_filter: RTL and testbench

// - Input conditioner directly upstream of freq_counter.
// - Synchronises the raw asynchronous pin SIGNAL_IN to clk.
// - Rejects pulses shorter than FILTER_CYCLES clocks, then drives the clean SIGNAL into freq_counter.
// - Also provides one-cycle edge strobes and a saturating count of rejected glitches for diagnostics.

---
 rtl/vin_signal_filter.sv | 137 +++++++++++++
 tb/tb_vin_signal_filter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vin_signal_filter.sv
// Input conditioner for freq_counter: synchronises SIGNAL_IN, rejects pulses
// shorter than FILTER_CYCLES clocks, and reports edges and rejected glitches.
module vin_signal_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 8,
  parameter int GLITCH_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SIGNAL_IN,
  input  logic                clear_glitches,
  output logic                SIGNAL,
  output logic                RISE,
  output logic                FALL,
  output logic [GLITCH_W-1:0] glitches
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_QH   = 2'd1,
    ST_HIGH = 2'd2,
    ST_QL   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   syncOut;
  state_t                 stateQ, stateD;
  logic [CNT_W-1:0]       cntQ, cntD;
  logic                   signalQ, signalD;
  logic                   riseQ, riseD;
  logic                   fallQ, fallD;
  logic [GLITCH_W-1:0]    glitchQ, glitchD;
  logic                   glitchInc;

  // Plain shift chain; the last flop is the only one the filter looks at.
  always_ff @(posedge clk) begin
    if (reset) syncQ <= '0;
    else       syncQ <= {syncQ[SYNC_STAGES-2:0], SIGNAL_IN};
  end

  assign syncOut = syncQ[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= ST_LOW;
      cntQ    <= '0;
      signalQ <= 1'b0;
      riseQ   <= 1'b0;
      fallQ   <= 1'b0;
      glitchQ <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      signalQ <= signalD;
      riseQ   <= riseD;
      fallQ   <= fallD;
      glitchQ <= glitchD;
    end
  end

  // A new level is accepted only after FILTER_CYCLES equal samples in a row.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    signalD   = signalQ;
    riseD     = 1'b0;
    fallD     = 1'b0;
    glitchInc = 1'b0;
    case (stateQ)
      ST_LOW: begin
        if (syncOut) begin
          if (FILTER_CYCLES == 1) begin
            stateD  = ST_HIGH;
            signalD = 1'b1;
            riseD   = 1'b1;
          end else begin
            stateD = ST_QH;
            cntD   = CNT_W'(1);
          end
        end
      end
      ST_QH: begin
        if (!syncOut) begin
          stateD    = ST_LOW;
          glitchInc = 1'b1;
        end else if (cntQ == CNT_LAST) begin
          stateD  = ST_HIGH;
          signalD = 1'b1;
          riseD   = 1'b1;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!syncOut) begin
          if (FILTER_CYCLES == 1) begin
            stateD  = ST_LOW;
            signalD = 1'b0;
            fallD   = 1'b1;
          end else begin
            stateD = ST_QL;
            cntD   = CNT_W'(1);
          end
        end
      end
      ST_QL: begin
        if (syncOut) begin
          stateD    = ST_HIGH;
          glitchInc = 1'b1;
        end else if (cntQ == CNT_LAST) begin
          stateD  = ST_LOW;
          signalD = 1'b0;
          fallD   = 1'b1;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      default: stateD = ST_LOW;
    endcase
  end

  // Clear wins over a same-cycle abort; the count sticks at all-ones.
  always_comb begin
    glitchD = glitchQ;
    if (clear_glitches)                   glitchD = '0;
    else if (glitchInc && (glitchQ != '1)) glitchD = glitchQ + GLITCH_W'(1);
  end

  assign SIGNAL   = signalQ;
  assign RISE     = riseQ;
  assign FALL     = fallQ;
  assign glitches = glitchQ;

endmodule

// File: tb/tb_vin_signal_filter.sv
// Directed bench for vin_signal_filter (SYNC_STAGES=2, FILTER_CYCLES=4); a
// second GLITCH_W=4 instance shares the stimulus to exercise saturation.
module tb_vin_signal_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sigIn = 1'b0;
  logic        clearGlitches = 1'b0;
  logic        sigOut, riseOut, fallOut;
  logic [15:0] glitchOut;
  logic        sigOut4, riseOut4, fallOut4;
  logic [3:0]  glitchOut4;

  int testsRun = 0;
  int testsFailed = 0;

  vin_signal_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .GLITCH_W(16)) dut (
    .clk(clk), .reset(reset), .SIGNAL_IN(sigIn), .clear_glitches(clearGlitches),
    .SIGNAL(sigOut), .RISE(riseOut), .FALL(fallOut), .glitches(glitchOut)
  );

  vin_signal_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .GLITCH_W(4)) dut4 (
    .clk(clk), .reset(reset), .SIGNAL_IN(sigIn), .clear_glitches(clearGlitches),
    .SIGNAL(sigOut4), .RISE(riseOut4), .FALL(fallOut4), .glitches(glitchOut4)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic applyStimulus(input logic inVal, input logic clrVal, input logic rstVal);
    sigIn         = inVal;
    clearGlitches = clrVal;
    reset         = rstVal;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  initial begin
    logic [6:0] hist;
    int riseCount;
    int fallCount;
    logic w;

    // Reset held with the pin high, then release.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("rst_signal", 32'(sigOut), 0);
    checkOutput("rst_rise", 32'(riseOut), 0);
    checkOutput("rst_fall", 32'(fallOut), 0);
    checkOutput("rst_glitches", 32'(glitchOut), 0);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_signal", 32'(sigOut), 32'(k >= 6));
      checkOutput("t1_rise", 32'(riseOut), 32'(k == 6));
      checkOutput("t1_fall", 32'(fallOut), 0);
    end
    checkOutput("t1_glitches", 32'(glitchOut), 0);

    // Return to a stable low level.
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("low_signal", 32'(sigOut), 0);
    checkOutput("low_glitches", 32'(glitchOut), 0);

    // 3-clock pulse is rejected and counted.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(k <= 3, 1'b0, 1'b0);
      checkOutput("t2a_signal", 32'(sigOut), 0);
      checkOutput("t2a_rise", 32'(riseOut), 0);
      checkOutput("t2a_fall", 32'(fallOut), 0);
    end
    checkOutput("t2a_glitches", 32'(glitchOut), 1);

    // 4-clock pulse passes through, delayed 6 clocks.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(k <= 4, 1'b0, 1'b0);
      checkOutput("t2b_signal", 32'(sigOut), 32'(k >= 6 && k <= 9));
      checkOutput("t2b_rise", 32'(riseOut), 32'(k == 6));
      checkOutput("t2b_fall", 32'(fallOut), 32'(k == 10));
    end
    checkOutput("t2b_glitches", 32'(glitchOut), 1);

    // 100/100 square wave for 10000 clocks.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_clear", 32'(glitchOut), 0);
    hist = '0;
    riseCount = 0;
    fallCount = 0;
    for (int n = 0; n < 10000; n++) begin
      w = ((n % 200) < 100);
      hist = {hist[5:0], w};
      applyStimulus(w, 1'b0, 1'b0);
      checkOutput("t3_signal", 32'(sigOut), 32'(hist[5]));
      checkOutput("t3_rise", 32'(riseOut), 32'(hist[5] & ~hist[6]));
      checkOutput("t3_fall", 32'(fallOut), 32'(~hist[5] & hist[6]));
      if (riseOut) riseCount++;
      if (fallOut) fallCount++;
    end
    checkOutput("t3_rise_count", 32'(riseCount), 50);
    checkOutput("t3_fall_count", 32'(fallCount), 50);
    checkOutput("t3_glitches", 32'(glitchOut), 0);

    // Twenty 2-clock pulses: 4-bit counter saturates at 15.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4_clear", 32'(glitchOut4), 0);
    for (int p = 0; p < 20; p++) begin
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
      if (p == 14) checkOutput("t4_at15", 32'(glitchOut4), 15);
      if (p == 15) checkOutput("t4_sat16", 32'(glitchOut4), 15);
    end
    checkOutput("t4_sat20", 32'(glitchOut4), 15);
    checkOutput("t4_wide20", 32'(glitchOut), 20);
    checkOutput("t4_signal", 32'(sigOut4), 0);

    // Clear coincides with an abort at the fifth edge.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_before", 32'(glitchOut), 20);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_cleared", 32'(glitchOut), 0);
    checkOutput("t5_cleared4", 32'(glitchOut4), 0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_after", 32'(glitchOut), 1);

    // Reset during high qualification (cnt=2 after the fourth edge).
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_pre_signal", 32'(sigOut), 0);
    checkOutput("t6_pre_glitches", 32'(glitchOut), 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t6_rst_signal", 32'(sigOut), 0);
    checkOutput("t6_rst_rise", 32'(riseOut), 0);
    checkOutput("t6_rst_glitches", 32'(glitchOut), 0);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t6_signal", 32'(sigOut), 32'(k >= 6));
      checkOutput("t6_rise", 32'(riseOut), 32'(k == 6));
    end
    checkOutput("t6_glitches", 32'(glitchOut), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
